// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: widths, ExcCodes, CP0 addresses, FSM states.
package exc_ctrl_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned FLAG_W = 6;
   localparam int unsigned CODE_W = 5;
   localparam int unsigned REG_W  = 5;

   // Bit positions inside excflags_i
   localparam int unsigned F_SYS  = 0;
   localparam int unsigned F_BP   = 1;
   localparam int unsigned F_RI   = 2;
   localparam int unsigned F_OV   = 3;
   localparam int unsigned F_TR   = 4;
   localparam int unsigned F_ERET = 5;

   // ExcCode values
   localparam logic [CODE_W-1:0] EXC_INT = CODE_W'(0);
   localparam logic [CODE_W-1:0] EXC_SYS = CODE_W'(8);
   localparam logic [CODE_W-1:0] EXC_BP  = CODE_W'(9);
   localparam logic [CODE_W-1:0] EXC_RI  = CODE_W'(10);
   localparam logic [CODE_W-1:0] EXC_OV  = CODE_W'(12);
   localparam logic [CODE_W-1:0] EXC_TR  = CODE_W'(13);

   // CP0 register addresses
   localparam logic [REG_W-1:0] CP0_STATUS = REG_W'(12);
   localparam logic [REG_W-1:0] CP0_CAUSE  = REG_W'(13);
   localparam logic [REG_W-1:0] CP0_EPC    = REG_W'(14);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      W_EPC    = 3'd1,
      W_CAUSE  = 3'd2,
      W_STATUS = 3'd3,
      REDIRECT = 3'd4
   } exc_state_e;

   // Context captured when an event is accepted
   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic              eret;
      logic              bd;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   status;
      logic [XLEN-1:0]   cause;
      logic [XLEN-1:0]   epc;
   } exc_ctx_t;

   // CP0 write port payload
   typedef struct packed {
      logic              we;
      logic [REG_W-1:0]  addr;
      logic [XLEN-1:0]   data;
   } cp0_wr_t;

   // Interrupts enabled (IE=1, EXL=0) and at least one unmasked pending line
   function automatic logic int_pending(input logic [XLEN-1:0] status,
                                        input logic [XLEN-1:0] cause);
      return status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
   endfunction

endpackage

// File: rtl/exc_ctrl_prio.sv
// Combinational event priority and ExcCode encoder.
module exc_prio
   import exc_ctrl_pkg::*;
(
   input  logic [FLAG_W-1:0] excflags_i,
   input  logic [XLEN-1:0]   cp0_status_i,
   input  logic [XLEN-1:0]   cp0_cause_i,
   output logic              event_c,
   output logic              eret_c,
   output logic [CODE_W-1:0] code_c
);

   // Interrupt > RI > Ov > Tr > Sys > Bp > eret
   always_comb begin
      event_c = 1'b0;
      eret_c  = 1'b0;
      code_c  = EXC_INT;
      if (int_pending(cp0_status_i, cp0_cause_i)) begin
         event_c = 1'b1;
         code_c  = EXC_INT;
      end else if (excflags_i[F_RI]) begin
         event_c = 1'b1;
         code_c  = EXC_RI;
      end else if (excflags_i[F_OV]) begin
         event_c = 1'b1;
         code_c  = EXC_OV;
      end else if (excflags_i[F_TR]) begin
         event_c = 1'b1;
         code_c  = EXC_TR;
      end else if (excflags_i[F_SYS]) begin
         event_c = 1'b1;
         code_c  = EXC_SYS;
      end else if (excflags_i[F_BP]) begin
         event_c = 1'b1;
         code_c  = EXC_BP;
      end else if (excflags_i[F_ERET]) begin
         event_c = 1'b1;
         eret_c  = 1'b1;
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt entry and eret sequencer driving the CP0 write port and pipeline redirect.
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0020
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              commit_valid_i,
   input  logic [FLAG_W-1:0] excflags_i,
   input  logic [XLEN-1:0]   inst_addr_i,
   input  logic              in_delayslot_i,
   input  logic [XLEN-1:0]   cp0_status_i,
   input  logic [XLEN-1:0]   cp0_cause_i,
   input  logic [XLEN-1:0]   cp0_epc_i,
   output logic              stall_o,
   output logic              flush_o,
   output logic [XLEN-1:0]   new_pc_o,
   output logic              cp0_we_o,
   output logic [REG_W-1:0]  cp0_waddr_o,
   output logic [XLEN-1:0]   cp0_wdata_o,
   output logic [CODE_W-1:0] exccode_o
);

   localparam logic [XLEN-1:0] EXL_MASK = XLEN'(2);

   exc_state_e        state_q, state_d;
   exc_ctx_t          ctx_q, ctx_d;
   cp0_wr_t           wr_d;
   logic              stall_d, flush_d;
   logic [XLEN-1:0]   new_pc_d;
   logic [CODE_W-1:0] code_d;

   logic              event_c, eret_c;
   logic [CODE_W-1:0] code_c;

   exc_prio u_prio (
      .excflags_i   (excflags_i),
      .cp0_status_i (cp0_status_i),
      .cp0_cause_i  (cp0_cause_i),
      .event_c      (event_c),
      .eret_c       (eret_c),
      .code_c       (code_c)
   );

   // Next state, context capture and output decode; outputs follow the state being entered
   always_comb begin
      state_d  = state_q;
      ctx_d    = ctx_q;
      wr_d     = '0;
      stall_d  = 1'b0;
      flush_d  = 1'b0;
      new_pc_d = '0;
      code_d   = '0;

      unique case (state_q)
         IDLE: begin
            if (commit_valid_i && event_c) begin
               ctx_d.code   = code_c;
               ctx_d.eret   = eret_c;
               ctx_d.bd     = in_delayslot_i;
               ctx_d.pc     = inst_addr_i;
               ctx_d.status = cp0_status_i;
               ctx_d.cause  = cp0_cause_i;
               ctx_d.epc    = cp0_epc_i;
               state_d      = eret_c ? W_STATUS : W_EPC;
            end
         end
         W_EPC:    state_d = W_CAUSE;
         W_CAUSE:  state_d = W_STATUS;
         W_STATUS: state_d = REDIRECT;
         REDIRECT: state_d = IDLE;
         default:  state_d = IDLE;
      endcase

      if (state_d != IDLE) begin
         stall_d = 1'b1;
         code_d  = ctx_d.code;
      end

      unique case (state_d)
         W_EPC: begin
            wr_d.we   = 1'b1;
            wr_d.addr = CP0_EPC;
            wr_d.data = ctx_d.bd ? (ctx_d.pc - XLEN'(4)) : ctx_d.pc;
         end
         W_CAUSE: begin
            wr_d.we   = 1'b1;
            wr_d.addr = CP0_CAUSE;
            wr_d.data = {ctx_d.bd, ctx_d.cause[30:7], ctx_d.code, ctx_d.cause[1:0]};
         end
         W_STATUS: begin
            wr_d.we   = 1'b1;
            wr_d.addr = CP0_STATUS;
            wr_d.data = ctx_d.eret ? (ctx_d.status & ~EXL_MASK) : (ctx_d.status | EXL_MASK);
         end
         REDIRECT: begin
            flush_d  = 1'b1;
            new_pc_d = ctx_d.eret ? ctx_d.epc : EXC_VECTOR;
         end
         default: ;
      endcase
   end

   // State, latched context and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ctx_q       <= '0;
         stall_o     <= 1'b0;
         flush_o     <= 1'b0;
         new_pc_o    <= '0;
         cp0_we_o    <= 1'b0;
         cp0_waddr_o <= '0;
         cp0_wdata_o <= '0;
         exccode_o   <= '0;
      end else begin
         state_q     <= state_d;
         ctx_q       <= ctx_d;
         stall_o     <= stall_d;
         flush_o     <= flush_d;
         new_pc_o    <= new_pc_d;
         cp0_we_o    <= wr_d.we;
         cp0_waddr_o <= wr_d.addr;
         cp0_wdata_o <= wr_d.data;
         exccode_o   <= code_d;
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed-vector bench for exc_ctrl.
module tb_exc_ctrl;

   logic        clk;
   logic        rst;
   logic        commit_valid_i;
   logic [5:0]  excflags_i;
   logic [31:0] inst_addr_i;
   logic        in_delayslot_i;
   logic [31:0] cp0_status_i;
   logic [31:0] cp0_cause_i;
   logic [31:0] cp0_epc_i;
   logic        stall_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        cp0_we_o;
   logic [4:0]  cp0_waddr_o;
   logic [31:0] cp0_wdata_o;
   logic [4:0]  exccode_o;

   int n_vec = 0;
   int n_err = 0;

   exc_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .commit_valid_i (commit_valid_i),
      .excflags_i     (excflags_i),
      .inst_addr_i    (inst_addr_i),
      .in_delayslot_i (in_delayslot_i),
      .cp0_status_i   (cp0_status_i),
      .cp0_cause_i    (cp0_cause_i),
      .cp0_epc_i      (cp0_epc_i),
      .stall_o        (stall_o),
      .flush_o        (flush_o),
      .new_pc_o       (new_pc_o),
      .cp0_we_o       (cp0_we_o),
      .cp0_waddr_o    (cp0_waddr_o),
      .cp0_wdata_o    (cp0_wdata_o),
      .exccode_o      (exccode_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // All outputs at their quiet values
   task automatic chk_idle(input string tag);
      chk({tag, ".stall"}, 32'(stall_o), 32'd0);
      chk({tag, ".flush"}, 32'(flush_o), 32'd0);
      chk({tag, ".newpc"}, new_pc_o, 32'd0);
      chk({tag, ".we"},    32'(cp0_we_o), 32'd0);
      chk({tag, ".waddr"}, 32'(cp0_waddr_o), 32'd0);
      chk({tag, ".wdata"}, cp0_wdata_o, 32'd0);
   endtask

   task automatic chk_wr(input string tag, input logic [4:0] addr, input logic [31:0] data);
      chk({tag, ".stall"}, 32'(stall_o), 32'd1);
      chk({tag, ".flush"}, 32'(flush_o), 32'd0);
      chk({tag, ".we"},    32'(cp0_we_o), 32'd1);
      chk({tag, ".waddr"}, 32'(cp0_waddr_o), 32'(addr));
      chk({tag, ".wdata"}, cp0_wdata_o, data);
   endtask

   task automatic chk_redirect(input string tag, input logic [31:0] pc);
      chk({tag, ".stall"}, 32'(stall_o), 32'd1);
      chk({tag, ".flush"}, 32'(flush_o), 32'd1);
      chk({tag, ".newpc"}, new_pc_o, pc);
      chk({tag, ".we"},    32'(cp0_we_o), 32'd0);
      chk({tag, ".wdata"}, cp0_wdata_o, 32'd0);
   endtask

   // Present one committing instruction, then junk (still valid) that must be ignored
   task automatic commit(input logic [5:0] f, input logic [31:0] pc, input logic ds,
                         input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep);
      @(negedge clk);
      commit_valid_i = 1'b1;
      excflags_i     = f;
      inst_addr_i    = pc;
      in_delayslot_i = ds;
      cp0_status_i   = st;
      cp0_cause_i    = ca;
      cp0_epc_i      = ep;
      @(posedge clk); #1;
      excflags_i     = 6'h3F;
      inst_addr_i    = 32'hDEAD_BEEF;
      in_delayslot_i = 1'b1;
      cp0_status_i   = 32'h0000_FF01;
      cp0_cause_i    = 32'h0000_FF00;
      cp0_epc_i      = 32'hCAFE_0000;
   endtask

   // Full exception entry, called just after the acceptance edge
   task automatic exp_exc(input string tag, input logic [31:0] epc, input logic [31:0] cause,
                          input logic [31:0] status, input logic [4:0] code);
      chk_wr({tag, ".epc"}, 5'd14, epc);
      chk({tag, ".code"}, 32'(exccode_o), 32'(code));
      @(posedge clk); #1;
      chk_wr({tag, ".cause"}, 5'd13, cause);
      @(posedge clk); #1;
      chk_wr({tag, ".status"}, 5'd12, status);
      @(posedge clk); #1;
      chk_redirect({tag, ".redir"}, 32'h0000_0020);
      commit_valid_i = 1'b0;
      @(posedge clk); #1;
      chk_idle({tag, ".after"});
   endtask

   task automatic exp_eret(input string tag, input logic [31:0] status, input logic [31:0] pc);
      chk_wr({tag, ".status"}, 5'd12, status);
      @(posedge clk); #1;
      chk_redirect({tag, ".redir"}, pc);
      commit_valid_i = 1'b0;
      @(posedge clk); #1;
      chk_idle({tag, ".after"});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      commit_valid_i = 1'b0;
      excflags_i = '0;
      inst_addr_i = '0;
      in_delayslot_i = 1'b0;
      cp0_status_i = '0;
      cp0_cause_i = '0;
      cp0_epc_i = '0;
      #1;
      chk_idle("reset");
      chk("reset.code", 32'(exccode_o), 32'd0);
      @(negedge clk); rst = 1'b1;

      // syscall at 0x100
      commit(6'h01, 32'h0000_0100, 1'b0, 32'h1000_0001, 32'h0000_0000, 32'h0);
      exp_exc("sys", 32'h0000_0100, 32'h0000_0020, 32'h1000_0003, 5'd8);

      // overflow in delay slot
      commit(6'h08, 32'h0000_0204, 1'b1, 32'h1000_0001, 32'h0000_0000, 32'h0);
      exp_exc("ov_ds", 32'h0000_0200, 32'h8000_0030, 32'h1000_0003, 5'd12);

      // interrupt beats RI; stale code bits in Cause are replaced
      commit(6'h04, 32'h0000_0300, 1'b0, 32'h1000_0401, 32'h0000_047C, 32'h0);
      exp_exc("int_ri", 32'h0000_0300, 32'h0000_0400, 32'h1000_0403, 5'd0);

      // priority: Ov over Tr/Sys/Bp, Tr over Sys, Sys over Bp, Bp over eret
      commit(6'h1B, 32'h0000_1000, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0);
      exp_exc("p_ov", 32'h0000_1000, 32'h0000_0030, 32'h0000_0002, 5'd12);
      commit(6'h13, 32'h0000_1004, 1'b0, 32'h0000_0000, 32'h0000_0003, 32'h0);
      exp_exc("p_tr", 32'h0000_1004, 32'h0000_0037, 32'h0000_0002, 5'd13);
      commit(6'h03, 32'h0000_1008, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0);
      exp_exc("p_sys", 32'h0000_1008, 32'h0000_0020, 32'h0000_0002, 5'd8);

      // breakpoint in delay slot at pc 2: EPC wraps
      commit(6'h22, 32'h0000_0002, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0);
      exp_exc("p_bp_wrap", 32'hFFFF_FFFE, 32'h8000_0024, 32'h0000_0002, 5'd9);

      // eret
      commit(6'h20, 32'h0000_0500, 1'b0, 32'h1000_0003, 32'h0000_0000, 32'h0000_0400);
      exp_eret("eret", 32'h1000_0001, 32'h0000_0400);

      // eret with EXL already clear
      commit(6'h20, 32'h0000_0504, 1'b0, 32'h1000_0001, 32'h0000_0000, 32'h0000_0800);
      exp_eret("eret_exl0", 32'h1000_0001, 32'h0000_0800);

      // pending interrupt masked by EXL=1: nothing happens
      @(negedge clk);
      commit_valid_i = 1'b1;
      excflags_i = 6'h00;
      cp0_status_i = 32'h1000_0403;
      cp0_cause_i = 32'h0000_0400;
      @(posedge clk); #1;
      chk_idle("int_exl");
      @(posedge clk); #1;
      chk_idle("int_exl2");

      // flags without commit_valid: nothing happens
      commit_valid_i = 1'b0;
      excflags_i = 6'h3F;
      cp0_status_i = 32'h1000_0401;
      @(posedge clk); #1;
      chk_idle("novalid");
      @(posedge clk); #1;
      chk_idle("novalid2");

      // reset asserted during W_CAUSE
      commit(6'h01, 32'h0000_0600, 1'b0, 32'h1000_0001, 32'h0000_0000, 32'h0);
      chk_wr("rstmid.epc", 5'd14, 32'h0000_0600);
      @(posedge clk); #1;
      chk_wr("rstmid.cause", 5'd13, 32'h0000_0020);
      #2 rst = 1'b0;
      #1;
      chk_idle("rstmid.async");
      chk("rstmid.code", 32'(exccode_o), 32'd0);
      commit_valid_i = 1'b1;
      excflags_i = 6'h01;
      inst_addr_i = 32'h0000_0700;
      in_delayslot_i = 1'b0;
      cp0_status_i = 32'h1000_0001;
      cp0_cause_i = 32'h0000_0000;
      @(posedge clk); #1;
      chk_idle("rstmid.held");
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      excflags_i = 6'h3F;
      inst_addr_i = 32'hDEAD_BEEF;
      exp_exc("postrst", 32'h0000_0700, 32'h0000_0020, 32'h1000_0003, 5'd8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h00000020, meaning the PC loaded on exception/interrupt entry.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port commit_valid_i, input, 1, the instruction at mem stage is committing this cycle.
REQ-005 SHALL have port excflags_i, input, 6, per-instruction flags: [0] syscall, [1] break, [2] reserved-instr, [3] overflow, [4] trap, [5] eret.
REQ-006 SHALL have port inst_addr_i, input, 32, PC of the committing instruction.
REQ-007 SHALL have port in_delayslot_i, input, 1, the committing instruction is in a branch delay slot.
REQ-008 SHALL have ports cp0_status_i, cp0_cause_i, cp0_epc_i, each input, 32, current CP0 Status/Cause/EPC values.
REQ-009 SHALL have port stall_o, output, 1, pipeline hold request.
REQ-010 SHALL have port flush_o, output, 1, one-cycle pipeline flush.
REQ-011 SHALL have port new_pc_o, output, 32, redirect target, valid only while flush_o=1.
REQ-012 SHALL have ports cp0_we_o (1), cp0_waddr_o (5), cp0_wdata_o (32), all outputs, forming the CP0 write port.
REQ-013 SHALL have port exccode_o, output, 5, the ExcCode of the event being serviced.

Function
REQ-014 SHALL use FSM states IDLE, W_EPC, W_CAUSE, W_STATUS, REDIRECT.
REQ-015 Interrupt pending SHALL be Status[0]=1 and Status[1]=0 and (Cause[15:8] & Status[15:8]) != 0.
REQ-016 In IDLE with commit_valid_i=1, SHALL take an event when an interrupt is pending or any flag is set; priority: interrupt(0) > RI(10) > Ov(12) > Tr(13) > Sys(8) > Bp(9) > eret.
REQ-017 On event acceptance SHALL latch code, inst_addr_i, in_delayslot_i, cp0_status_i, cp0_cause_i and cp0_epc_i; later data SHALL come only from latched copies.
REQ-018 For a non-eret event: IDLE -> W_EPC -> W_CAUSE -> W_STATUS -> REDIRECT -> IDLE, one cycle each; flush_o asserts 4 cycles after acceptance.
REQ-019 W_EPC SHALL write addr 14 with data pc-4 if delay slot, else pc (32-bit wrap-around).
REQ-020 W_CAUSE SHALL write addr 13 with the latched cause, [31]=BD, [6:2]=code.
REQ-021 W_STATUS for an exception SHALL write addr 12 with the latched status and bit1 (EXL) set.
REQ-022 For eret SHALL go IDLE -> W_STATUS (EXL cleared) -> REDIRECT, with new_pc_o equal to the latched EPC.
REQ-023 REDIRECT SHALL assert flush_o for exactly one cycle with new_pc_o=EXC_VECTOR for exceptions and interrupts.
REQ-024 cp0_we_o SHALL be high only in W_EPC/W_CAUSE/W_STATUS; otherwise waddr/wdata SHALL be 0.
REQ-025 stall_o SHALL be high in every non-IDLE state, including REDIRECT.
REQ-026 Inputs SHALL be ignored outside IDLE; commit_valid_i=0 SHALL never start an event.
REQ-027 An interrupt and a flag in the same cycle SHALL service the interrupt only, recording EPC as the flagged instruction's address.
REQ-028 eret while EXL=0 SHALL still be serviced as in REQ-022.

Reset
REQ-029 rst low SHALL asynchronously force IDLE and set every output and latched register to 0, including mid-sequence; no partial CP0 write SHALL complete.
REQ-030 After rst deassertion, the first event SHALL be acceptable on the first rising edge.

Structure
REQ-031 State encodings, ExcCode values and CP0 register addresses 12/13/14 SHALL live in the shared defines package.
REQ-032 The priority/ExcCode encode SHALL be one combinational sub-module, exc_prio.

Verification
REQ-033 Commit syscall at pc 0x00000100 with status 0x10000001 -> writes EPC=0x100, Cause[6:2]=8, Status=0x10000003; flush with new_pc 0x20 on cycle +4.
REQ-034 Overflow in delay slot at pc 0x204 -> EPC=0x200, Cause[31]=1, Cause[6:2]=12.
REQ-035 Status=0x10000401 and Cause[10]=1 with RI flagged at pc 0x300 -> code 0; EPC=0x300; no RI service.
REQ-036 eret with EPC=0x00000400 and status 0x10000003 -> single Status write 0x10000001; flush with new_pc 0x400 on cycle +2.
REQ-037 rst pulsed low during W_CAUSE -> outputs 0 immediately; a syscall accepted right after reset completes the full sequence.
REQ-038 Interrupt pending with EXL=1, or commit_valid_i=0 with flags set -> no stall_o, no write, no flush.
